// File: rtl/emif_mon_pkg.sv
// Shared types and constants for the EMIF calibration status monitor.
// Contents:
//   ch_state_e        per-channel health state codes
//   MS_BIT_*          ms-counter bit indices used as LED blink sources
//   LED_OFS_*         LED bit offsets above the per-channel indicators
//   cycles_per_ms()   prescaler period derived from the clock frequency
package emif_mon_pkg;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_READY   = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_LOST    = 3'd4
    } ch_state_e;

    localparam int MS_BIT_FAST  = 6;   // ~8 Hz blink
    localparam int MS_BIT_SLOW  = 8;   // ~2 Hz blink
    localparam int MS_BIT_HEART = 9;   // ~1 Hz heartbeat

    // o_led[NUM_CH + LED_OFS_*]
    localparam int LED_OFS_ALL_READY = 0;
    localparam int LED_OFS_HEARTBEAT = 1;

    // Clamped to 1 so a sub-kHz clock still produces a tick.
    function automatic int unsigned cycles_per_ms(input int unsigned clk_hz);
        int unsigned c;
        c = clk_hz / 1000;
        if (c == 0) c = 1;
        return c;
    endfunction

endpackage

// File: rtl/emif_mon_tick.sv
// Millisecond time base shared by all monitor channels.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   o_tick       one-cycle pulse every CYC_PER_MS cycles
//   o_ms_cnt     free-running 16-bit ms count, advances on each tick
module emif_mon_tick #(
    parameter int unsigned CYC_PER_MS = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_tick,
    output logic [15:0] o_ms_cnt
);

    localparam int PW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [PW-1:0] RELOAD = PW'(CYC_PER_MS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_q, ms_d;
    logic          tick;

    // Down-counter with terminal-count compare; reload on terminal count.
    always_comb begin
        tick    = (presc_q == '0);
        presc_d = tick ? RELOAD : presc_q - PW'(1);
        ms_d    = tick ? ms_q + 16'd1 : ms_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= RELOAD;
            ms_q    <= 16'd0;
        end else begin
            presc_q <= presc_d;
            ms_q    <= ms_d;
        end
    end

    assign o_tick   = tick;
    assign o_ms_cnt = ms_q;

endmodule

// File: rtl/emif_status_monitor.sv
// Per-channel EMIF calibration health monitor driving board LEDs.
// Optional feature macro: EMIF_MON_LOST_CNT_EN (per-channel READY->LOST counter).
// Ports:
//   clk50m_max10, max10_resetn     clock, async active-low reset
//   i_init_done/i_cal_success/i_cal_fail [NUM_CH]  raw async status
//   i_clear                        sync pulse, releases sticky error states
//   o_ch_state [3*NUM_CH]          per-channel state code
//   o_all_ready, o_any_error       registered summaries
//   o_led [NUM_CH+2]               channel LEDs, all-ready, heartbeat
//   o_lost_cnt [8*NUM_CH]          READY->LOST counts (0 unless macro set)
//
// state   | meaning
// WAIT    | calibration in progress, timeout timer running
// READY   | init_done and cal_success up, no fail
// FAIL    | cal_fail seen in WAIT (sticky)
// TIMEOUT | no result within CAL_TIMEOUT_MS (sticky)
// LOST    | READY status dropped or fail raised (sticky)
module emif_status_monitor
    import emif_mon_pkg::*;
#(
    parameter int NUM_CH         = 1,
    parameter int CLK_HZ         = 50000000,
    parameter int CAL_TIMEOUT_MS = 500,
    parameter int SYNC_STAGES    = 2,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                  clk50m_max10,
    input  logic                  max10_resetn,
    input  logic [NUM_CH-1:0]     i_init_done,
    input  logic [NUM_CH-1:0]     i_cal_success,
    input  logic [NUM_CH-1:0]     i_cal_fail,
    input  logic                  i_clear,
    output logic [3*NUM_CH-1:0]   o_ch_state,
    output logic                  o_all_ready,
    output logic                  o_any_error,
    output logic [NUM_CH+1:0]     o_led,
    output logic [8*NUM_CH-1:0]   o_lost_cnt
);

    localparam int unsigned       CYC_PER_MS = cycles_per_ms(CLK_HZ);
    localparam logic [15:0]       TIMEOUT_MS = 16'(CAL_TIMEOUT_MS);
    localparam logic [NUM_CH+1:0] LED_OFF    = (LED_ACTIVE_LOW != 0) ? '1 : '0;

    logic        tick;
    logic [15:0] ms_cnt;
    logic        unused_ms;

    logic [NUM_CH-1:0] rdy, err, led_ch;

    logic              all_ready_d, all_ready_q;
    logic              any_error_d, any_error_q;
    logic [NUM_CH+1:0] led_d, led_q;

    emif_mon_tick #(.CYC_PER_MS(CYC_PER_MS)) u_tick (
        .clk      (clk50m_max10),
        .rst_n    (max10_resetn),
        .o_tick   (tick),
        .o_ms_cnt (ms_cnt)
    );

    assign unused_ms = ^{ms_cnt[15:10], ms_cnt[7], ms_cnt[5:0]};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [2:0]  sync_q [SYNC_STAGES];
        logic [2:0]  sync_d [SYNC_STAGES];
        logic        init_s, succ_s, fail_s;
        ch_state_e   state_q, state_d;
        logic [15:0] timer_q, timer_d;
        logic        led_bit;

        always_comb begin
            sync_d[0] = {i_cal_fail[g], i_cal_success[g], i_init_done[g]};
            for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
        end

        assign {fail_s, succ_s, init_s} = sync_q[SYNC_STAGES-1];

        // i_clear only acts on sticky states, and there it overrides whatever
        // the status inputs would otherwise cause that cycle.
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            case (state_q)
                ST_WAIT: begin
                    if (fail_s)
                        state_d = ST_FAIL;
                    else if (init_s && succ_s)
                        state_d = ST_READY;
                    else if (tick && ((timer_q + 16'd1) >= TIMEOUT_MS))
                        state_d = ST_TIMEOUT;

                    if (state_d != ST_WAIT) timer_d = 16'd0;
                    else if (tick)          timer_d = timer_q + 16'd1;
                end
                ST_READY: begin
                    if (!init_s || !succ_s || fail_s) state_d = ST_LOST;
                end
                ST_FAIL, ST_TIMEOUT, ST_LOST: begin
                    if (i_clear) begin
                        state_d = ST_WAIT;
                        timer_d = 16'd0;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    timer_d = 16'd0;
                end
            endcase
        end

        always_ff @(posedge clk50m_max10 or negedge max10_resetn) begin
            if (!max10_resetn) begin
                for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 3'b000;
                state_q <= ST_WAIT;
                timer_q <= 16'd0;
            end else begin
                for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
                state_q <= state_d;
                timer_q <= timer_d;
            end
        end

        always_comb begin
            led_bit = 1'b0;
            case (state_q)
                ST_WAIT:             led_bit = ms_cnt[MS_BIT_SLOW];
                ST_READY:            led_bit = 1'b1;
                ST_FAIL, ST_TIMEOUT: led_bit = ms_cnt[MS_BIT_FAST];
                default:             led_bit = 1'b0;
            endcase
        end

        assign o_ch_state[3*g +: 3] = state_q;
        assign rdy[g]    = (state_q == ST_READY);
        assign err[g]    = (state_q == ST_FAIL) || (state_q == ST_TIMEOUT) ||
                           (state_q == ST_LOST);
        assign led_ch[g] = led_bit;

`ifdef EMIF_MON_LOST_CNT_EN
        logic [7:0] lost_cnt_q, lost_cnt_d;
        logic       lost_evt;

        always_comb begin
            lost_evt   = (state_q == ST_READY) && (state_d == ST_LOST);
            lost_cnt_d = (lost_evt && (lost_cnt_q != 8'hFF)) ? lost_cnt_q + 8'd1
                                                             : lost_cnt_q;
        end

        always_ff @(posedge clk50m_max10 or negedge max10_resetn) begin
            if (!max10_resetn) lost_cnt_q <= 8'd0;
            else               lost_cnt_q <= lost_cnt_d;
        end

        assign o_lost_cnt[8*g +: 8] = lost_cnt_q;
`else
        assign o_lost_cnt[8*g +: 8] = 8'd0;
`endif
    end

    // Polarity is applied only here so every internal signal stays active-high.
    always_comb begin
        all_ready_d = &rdy;
        any_error_d = |err;
        led_d = '0;
        led_d[NUM_CH-1:0]                  = led_ch;
        led_d[NUM_CH + LED_OFS_ALL_READY]  = all_ready_d;
        led_d[NUM_CH + LED_OFS_HEARTBEAT]  = ms_cnt[MS_BIT_HEART];
        if (LED_ACTIVE_LOW != 0) led_d = ~led_d;
    end

    always_ff @(posedge clk50m_max10 or negedge max10_resetn) begin
        if (!max10_resetn) begin
            all_ready_q <= 1'b0;
            any_error_q <= 1'b0;
            led_q       <= LED_OFF;
        end else begin
            all_ready_q <= all_ready_d;
            any_error_q <= any_error_d;
            led_q       <= led_d;
        end
    end

    assign o_all_ready = all_ready_q;
    assign o_any_error = any_error_q;
    assign o_led       = led_q;

endmodule

// File: tb/tb_emif_status_monitor.sv
// Directed bench for emif_status_monitor: NUM_CH=2, CLK_HZ=10000 (tick every
// 10 cycles), CAL_TIMEOUT_MS=3, SYNC_STAGES=2, active-low LEDs.
module tb_emif_status_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  init_done, cal_success, cal_fail;
    logic        clr;
    logic [5:0]  ch_state;
    logic        all_ready, any_error;
    logic [3:0]  led;
    logic [15:0] lost_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

`ifdef EMIF_MON_LOST_CNT_EN
    localparam int EXP_LC10  = 10;
    localparam int EXP_LCSAT = 255;
`else
    localparam int EXP_LC10  = 0;
    localparam int EXP_LCSAT = 0;
`endif

    emif_status_monitor #(
        .NUM_CH(2), .CLK_HZ(10000), .CAL_TIMEOUT_MS(3),
        .SYNC_STAGES(2), .LED_ACTIVE_LOW(1)
    ) dut (
        .clk50m_max10  (clk),
        .max10_resetn  (rst_n),
        .i_init_done   (init_done),
        .i_cal_success (cal_success),
        .i_cal_fail    (cal_fail),
        .i_clear       (clr),
        .o_ch_state    (ch_state),
        .o_all_ready   (all_ready),
        .o_any_error   (any_error),
        .o_led         (led),
        .o_lost_cnt    (lost_cnt)
    );

    always #5 clk = ~clk;

    // Posedges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] st(input int ch);
        return ch_state[3*ch +: 3];
    endfunction

    // Returns 1 ns after posedge number n (outputs settled, safe to drive).
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input int ch, input logic [2:0] code, input string tag);
        for (int k = 0; k < 20 && st(ch) != code; k++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, 32'(st(ch)), 32'(code));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        init_done = 2'b00; cal_success = 2'b00; cal_fail = 2'b00; clr = 1'b0;
        #2 rst_n = 1'b0;
        #6;
        chk("rst_state",     32'(ch_state),  32'h0);
        chk("rst_all_ready", 32'(all_ready), 32'h0);
        chk("rst_any_error", 32'(any_error), 32'h0);
        chk("rst_led",       32'(led),       32'hF);
        chk("rst_lost_cnt",  32'(lost_cnt),  32'h0);
        #4 rst_n = 1'b1;

        // ch0 becomes ready; 3-cycle input latency
        wait_cyc(5);  init_done[0] = 1'b1; cal_success[0] = 1'b1;
        wait_cyc(7);  chk("ch0_latency_wait", 32'(st(0)), 32'd0);
        wait_cyc(8);  chk("ch0_ready",        32'(st(0)), 32'd1);
                      chk("led0_pre_ready",   32'(led[0]), 32'd1);
                      chk("all_ready_ch1_wait", 32'(all_ready), 32'd0);
        wait_cyc(9);  chk("led0_ready_on",    32'(led[0]), 32'd0);
                      chk("led_allrdy_off",   32'(led[2]), 32'd1);

        // ch1 times out on the third ms tick
        wait_cyc(29); chk("ch1_pre_timeout",  32'(st(1)), 32'd0);
        wait_cyc(30); chk("ch1_timeout",      32'(st(1)), 32'd3);
                      chk("any_err_lag",      32'(any_error), 32'd0);
        wait_cyc(31); chk("any_err_timeout",  32'(any_error), 32'd1);
                      chk("led1_fast_off",    32'(led[1]), 32'd1);
        wait_cyc(640);  chk("led1_ms63_off",  32'(led[1]), 32'd1);
        wait_cyc(641);  chk("led1_ms64_on",   32'(led[1]), 32'd0);
        wait_cyc(1281); chk("led1_ms128_off", 32'(led[1]), 32'd1);
        wait_cyc(5120); chk("heartbeat_off",  32'(led[3]), 32'd1);
        wait_cyc(5121); chk("heartbeat_on",   32'(led[3]), 32'd0);

        // clear ch1 out of TIMEOUT with good status
        clr = 1'b1; init_done[1] = 1'b1; cal_success[1] = 1'b1;
        wait_cyc(5122); clr = 1'b0;
                        chk("ch1_clr_wait",    32'(st(1)), 32'd0);
                        chk("ch0_clr_noeffect", 32'(st(0)), 32'd1);
        wait_cyc(5124); chk("ch1_ready",       32'(st(1)), 32'd1);
                        chk("all_ready_lag",   32'(all_ready), 32'd0);
        wait_cyc(5125); chk("all_ready_both",  32'(all_ready), 32'd1);
                        chk("any_err_cleared", 32'(any_error), 32'd0);
                        chk("led_allrdy_on",   32'(led[2]), 32'd0);

        // ch0 READY -> LOST on success drop, holds until clear
        wait_cyc(5130); cal_success[0] = 1'b0;
        wait_cyc(5132); chk("ch0_pre_lost",    32'(st(0)), 32'd1);
        wait_cyc(5133); chk("ch0_lost",        32'(st(0)), 32'd4);
                        cal_success[0] = 1'b1;
        wait_cyc(5134); chk("any_err_lost",    32'(any_error), 32'd1);
                        chk("led0_lost_off",   32'(led[0]), 32'd1);
                        chk("all_ready_lost",  32'(all_ready), 32'd0);
        wait_cyc(5140); chk("ch0_lost_sticky", 32'(st(0)), 32'd4);
                        clr = 1'b1;
        wait_cyc(5141); clr = 1'b0;
                        chk("ch0_lost_clr",    32'(st(0)), 32'd0);
        wait_cyc(5142); chk("ch0_reready",     32'(st(0)), 32'd1);

        // fail + success together: clear wins one cycle, then FAIL over READY
        wait_cyc(5150); cal_fail[0] = 1'b1;
        wait_cyc(5153); chk("ch0_fail_lost",   32'(st(0)), 32'd4);
                        clr = 1'b1;
        wait_cyc(5154); clr = 1'b0;
                        chk("clr_beats_fail",  32'(st(0)), 32'd0);
        wait_cyc(5155); chk("fail_over_ready", 32'(st(0)), 32'd2);
                        chk("ch1_still_ready", 32'(st(1)), 32'd1);

        // async reset in the middle of FAIL
        wait_cyc(5160);
        rst_n = 1'b0;
        #1;
        chk("arst_state",     32'(ch_state),  32'h0);
        chk("arst_led",       32'(led),       32'hF);
        chk("arst_all_ready", 32'(all_ready), 32'h0);
        chk("arst_any_error", 32'(any_error), 32'h0);

        // READY->LOST->clear loop on ch1
        init_done = 2'b10; cal_success = 2'b10; cal_fail = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            wait_state(1, 3'd1, "lc_ready");
            cal_success[1] = 1'b0;
            wait_state(1, 3'd4, "lc_lost");
            cal_success[1] = 1'b1;
            clr = 1'b1;
            @(posedge clk); #1;
            clr = 1'b0;
            if (n == 9) chk("lost_cnt_10", 32'(lost_cnt[15:8]), 32'(EXP_LC10));
        end
        chk("lost_cnt_sat",  32'(lost_cnt[15:8]), 32'(EXP_LCSAT));
        chk("lost_cnt_ch0",  32'(lost_cnt[7:0]),  32'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        chk("lost_cnt_clr_keep", 32'(lost_cnt[15:8]), 32'(EXP_LCSAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/emif_status_monitor.md
Name: emif_status_monitor

Overview:
- Parametrised per-channel monitor for EMIF calibration status (init_done / cal_success / cal_fail), replacing direct status-to-LED wiring.
- Synchronises raw status, runs a per-channel health FSM with calibration timeout and sticky error capture, and drives encoded state plus blinking board LEDs.
- Sits in the top level between the EMIF status conduits and user_led.

Parameters:
- NUM_CH, 1, number of EMIF channels monitored (1..8)
- CLK_HZ, 50000000, frequency of clk50m_max10 in Hz
- CAL_TIMEOUT_MS, 500, ms allowed in WAIT before TIMEOUT (1..65535)
- SYNC_STAGES, 2, synchroniser depth for status inputs (>=2)
- LED_ACTIVE_LOW, 1, 1 = o_led inverted at output

Ports:
- clk50m_max10  in  1  system clock
- max10_resetn  in  1  asynchronous active-low reset
- i_init_done  in  NUM_CH  raw local_init_done per channel, async
- i_cal_success  in  NUM_CH  raw local_cal_success per channel, async
- i_cal_fail  in  NUM_CH  raw local_cal_fail per channel, async
- i_clear  in  1  synchronous pulse; clears sticky error states
- o_ch_state  out  3*NUM_CH  per-channel FSM state code, channel i at [3i+2:3i]
- o_all_ready  out  1  every channel in READY
- o_any_error  out  1  any channel in FAIL, TIMEOUT or LOST
- o_led  out  NUM_CH+2  [i]=channel i indicator, [NUM_CH]=all_ready, [NUM_CH+1]=heartbeat
- o_lost_cnt  out  8*NUM_CH  per-channel READY->LOST event count (optional feature)

Behaviour:
- Clock and reset: one clock (clk50m_max10); reset asynchronous, active-low (max10_resetn).
- Reset values: all FSMs WAIT (code 0); timers 0; o_all_ready=0; o_any_error=0; o_lost_cnt=0; o_led = all logical-off (all 1s when LED_ACTIVE_LOW=1).
- Synchronisation: each status bit passes through SYNC_STAGES flops. FSM acts on the synced value one cycle later. Input-to-o_ch_state latency = SYNC_STAGES+1 cycles.
- ms tick: single-cycle pulse every CLK_HZ/1000 cycles from a shared prescaler. A free-running 16-bit ms counter advances on each tick.
- State codes: WAIT=0, READY=1, FAIL=2, TIMEOUT=3, LOST=4.
- WAIT -> FAIL: synced cal_fail=1. Takes priority over success when both are high in the same cycle.
- WAIT -> READY: init_done=1 and cal_success=1 and cal_fail=0.
- WAIT -> TIMEOUT: channel ms timer reaches CAL_TIMEOUT_MS on a tick. The timer increments only on ticks while in WAIT and clears on leaving WAIT.
- READY -> LOST: init_done or cal_success deasserts, or cal_fail asserts.
- Sticky states: FAIL, TIMEOUT and LOST hold until i_clear, then go to WAIT with the timer cleared. If fail is still asserted, re-entry to FAIL happens the next cycle.
- i_clear in WAIT or READY: no effect.
- i_clear coincident with a transition condition: the clear wins for that cycle.
- Outputs are registered.
  - o_all_ready = AND over channels of (state==READY).
  - o_any_error = OR over channels of (state in FAIL/TIMEOUT/LOST).
- LED channel bit by state:
  - WAIT: slow blink, ms counter bit 8.
  - READY: solid on.
  - FAIL/TIMEOUT: fast blink, ms counter bit 6.
  - LOST: solid off.
- Heartbeat LED: ms counter bit 9.
- Polarity: LED_ACTIVE_LOW inversion is applied in the final register stage only.

Optional Feature:
- Macro: EMIF_MON_LOST_CNT_EN.
- Defined: per-channel 8-bit counter increments on each READY->LOST transition, saturates at 255, and is unaffected by i_clear (reset only).
- Undefined: o_lost_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Package emif_mon_pkg:
  - ch_state_e enum (3-bit, codes above)
  - LED bit-index localparams
  - function cycles_per_ms(CLK_HZ)
- Sub-module emif_mon_tick: prescaler plus 16-bit ms counter; outputs tick and ms count. One instance, shared by all channels.
- Per-channel FSMs built in a generate loop within this module.

Test Plan:
- Sim params for all cases: CLK_HZ=10000 (tick every 10 cycles), CAL_TIMEOUT_MS=3, NUM_CH=2.
- Raise init_done and cal_success on ch0 at cycle 5 -> ch0 state=1 at cycle 8; o_all_ready stays 0 until ch1 is also ready, then 1; o_led[0]=0 (active-low on).
- Hold ch1 status low -> ch1 state=3 after the 3rd ms tick (cycle ~30); o_any_error=1; o_led[1] toggles every 64 ticks.
- Drive cal_fail=1 and cal_success=1 together on ch0 -> state=2, not 1.
- Ch0 READY, then drop cal_success -> state=4; hold 4 after success returns; pulse i_clear -> WAIT, then READY 1 cycle later.
- Assert max10_resetn=0 mid-FAIL -> all states 0, o_led all 1s immediately (async).
- With EMIF_MON_LOST_CNT_EN, force 300 READY->LOST->clear cycles on ch1 -> o_lost_cnt[15:8]=255; i_clear leaves the count intact.
